// File: rtl/idex_stage_reg_pkg.sv
// Shared pipeline package: parameter defaults, the packed control bundle
// carried through ID/EX, EX/MEM and MEM/WB, and the ID/EX stage action.
package idex_stage_reg_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned REG_AW_DEF   = 4;
  localparam int unsigned OP_W_DEF     = 4;
  localparam int unsigned BUBBLE_CNT_W = 16;

  // Decoded control bits; field order matches {MReg, MR, MW, ALU_src, EnRW}.
  typedef struct packed {
    logic mreg;
    logic mr;
    logic mw;
    logic alu_src;
    logic en_rw;
  } ctrl_t;

  // What the stage register does on the next rising edge.
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_BUBBLE = 2'd3
  } stage_act_e;

  // Edge priority: flush beats a downstream stall, which beats a load-use bubble.
  function automatic stage_act_e select_act(input logic flush,
                                            input logic ex_stall,
                                            input logic load_use);
    if (flush)    return ACT_FLUSH;
    if (ex_stall) return ACT_HOLD;
    if (load_use) return ACT_BUBBLE;
    return ACT_LOAD;
  endfunction

  // An invalid slot must never carry memory or register-file side effects.
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
    ctrl_t g;
    g = c;
    if (!valid) begin
      g.mreg  = 1'b0;
      g.mr    = 1'b0;
      g.mw    = 1'b0;
      g.en_rw = 1'b0;
    end
    return g;
  endfunction

endpackage

// File: rtl/idex_stage_reg_hazard_detect.sv
// Load-use hazard comparator: a load in EX whose destination register is read
// by the instruction currently in ID.
module idex_hazard_detect #(
  parameter int unsigned REG_AW = 4
) (
  input  logic              ex_valid_i,
  input  logic              ex_mr_i,
  input  logic              ex_en_rw_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  output logic              load_use_o
);

  assign load_use_o = ex_valid_i & ex_mr_i & ex_en_rw_i & id_valid_i &
                      ((ex_rd_i == id_rs_i) | (ex_rd_i == id_rt_i));

endmodule

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline stage register with flush, downstream stall and load-use
// bubble insertion. Optional bubble counter enabled by IDEX_BUBBLE_CNT_EN.
module idex_stage_reg
  import idex_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              MReg,
  input  logic              MR,
  input  logic              MW,
  input  logic              ALU_src,
  input  logic              EnRW,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] rd1_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [DATA_W-1:0] sign_ext_in,
  input  logic [REG_AW-1:0] reg_rs_in,
  input  logic [REG_AW-1:0] reg_rt_in,
  input  logic [REG_AW-1:0] reg_rd_in,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              valid_out,
  output logic              MReg_out,
  output logic              MR_out,
  output logic              MW_out,
  output logic              ALU_src_out,
  output logic              EnRW_out,
  output logic [OP_W-1:0]   opcode_out,
  output logic [DATA_W-1:0] rd1_out,
  output logic [DATA_W-1:0] rd2_out,
  output logic [DATA_W-1:0] sign_ext_out,
  output logic [REG_AW-1:0] reg_rs_out,
  output logic [REG_AW-1:0] reg_rt_out,
  output logic [REG_AW-1:0] reg_rd_out,
  output logic              id_hold
`ifdef IDEX_BUBBLE_CNT_EN
  ,
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt
`endif
);

  ctrl_t              ctrl_in;
  ctrl_t              ctrl_q,   ctrl_d;
  logic               valid_q,  valid_d;
  logic [OP_W-1:0]    opcode_q, opcode_d;
  logic [DATA_W-1:0]  rd1_q,    rd1_d;
  logic [DATA_W-1:0]  rd2_q,    rd2_d;
  logic [DATA_W-1:0]  imm_q,    imm_d;
  logic [REG_AW-1:0]  rs_q,     rs_d;
  logic [REG_AW-1:0]  rt_q,     rt_d;
  logic [REG_AW-1:0]  rd_q,     rd_d;
  logic               load_use;
  stage_act_e         act;

  assign ctrl_in = {MReg, MR, MW, ALU_src, EnRW};

  idex_hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid_i (valid_q),
    .ex_mr_i    (ctrl_q.mr),
    .ex_en_rw_i (ctrl_q.en_rw),
    .ex_rd_i    (rd_q),
    .id_valid_i (in_valid),
    .id_rs_i    (reg_rs_in),
    .id_rt_i    (reg_rt_in),
    .load_use_o (load_use)
  );

  assign act     = select_act(flush, ex_stall, load_use);
  assign id_hold = (ex_stall | load_use) & ~flush & ~rst;

  // Next-state selection for the stage contents.
  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    opcode_d = opcode_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    imm_d    = imm_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    case (act)
      ACT_LOAD: begin
        valid_d  = in_valid;
        ctrl_d   = gate_ctrl(ctrl_in, in_valid);
        opcode_d = opcode;
        rd1_d    = rd1_in;
        rd2_d    = rd2_in;
        imm_d    = sign_ext_in;
        rs_d     = reg_rs_in;
        rt_d     = reg_rt_in;
        rd_d     = reg_rd_in;
      end
      ACT_FLUSH, ACT_BUBBLE: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
      default: ; // ACT_HOLD keeps everything
    endcase
  end

  // Stage register state with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      opcode_q <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      opcode_q <= opcode_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      imm_q    <= imm_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
    end
  end

  assign valid_out    = valid_q;
  assign MReg_out     = ctrl_q.mreg;
  assign MR_out       = ctrl_q.mr;
  assign MW_out       = ctrl_q.mw;
  assign ALU_src_out  = ctrl_q.alu_src;
  assign EnRW_out     = ctrl_q.en_rw;
  assign opcode_out   = opcode_q;
  assign rd1_out      = rd1_q;
  assign rd2_out      = rd2_q;
  assign sign_ext_out = imm_q;
  assign reg_rs_out   = rs_q;
  assign reg_rt_out   = rt_q;
  assign reg_rd_out   = rd_q;

`ifdef IDEX_BUBBLE_CNT_EN
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_q;

  // Saturating count of load-use bubbles actually inserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else if (act == ACT_BUBBLE && bubble_cnt_q != '1) begin
      bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_idex_stage_reg.sv
// Self-checking bench for idex_stage_reg (optionally with IDEX_BUBBLE_CNT_EN).
module tb_idex_stage_reg;

  typedef struct {
    logic        in_valid;
    logic [4:0]  ctrl;      // {MReg, MR, MW, ALU_src, EnRW}
    logic [3:0]  opcode;
    logic [31:0] rd1, rd2, imm;
    logic [3:0]  rs, rt, rd;
    logic        stall, flush;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        hold;
    logic        valid;
    logic [4:0]  ctrl;
    logic [3:0]  opcode;
    logic [31:0] rd1;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [4:0]  ctrl;
    logic [3:0]  opcode;
    logic [31:0] rd1, rd2, imm;
    logic [3:0]  rs, rt, rd;
    int unsigned bubbles;
  } model_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  stim_t drv;
  model_t m;

  logic        valid_out, MReg_out, MR_out, MW_out, ALU_src_out, EnRW_out, id_hold;
  logic [3:0]  opcode_out, reg_rs_out, reg_rt_out, reg_rd_out;
  logic [31:0] rd1_out, rd2_out, sign_ext_out;
`ifdef IDEX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  idex_stage_reg dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (drv.in_valid),
    .MReg        (drv.ctrl[4]),
    .MR          (drv.ctrl[3]),
    .MW          (drv.ctrl[2]),
    .ALU_src     (drv.ctrl[1]),
    .EnRW        (drv.ctrl[0]),
    .opcode      (drv.opcode),
    .rd1_in      (drv.rd1),
    .rd2_in      (drv.rd2),
    .sign_ext_in (drv.imm),
    .reg_rs_in   (drv.rs),
    .reg_rt_in   (drv.rt),
    .reg_rd_in   (drv.rd),
    .ex_stall    (drv.stall),
    .flush       (drv.flush),
    .valid_out   (valid_out),
    .MReg_out    (MReg_out),
    .MR_out      (MR_out),
    .MW_out      (MW_out),
    .ALU_src_out (ALU_src_out),
    .EnRW_out    (EnRW_out),
    .opcode_out  (opcode_out),
    .rd1_out     (rd1_out),
    .rd2_out     (rd2_out),
    .sign_ext_out(sign_ext_out),
    .reg_rs_out  (reg_rs_out),
    .reg_rt_out  (reg_rt_out),
    .reg_rd_out  (reg_rd_out),
    .id_hold     (id_hold)
`ifdef IDEX_BUBBLE_CNT_EN
    ,
    .bubble_cnt  (bubble_cnt)
`endif
  );

  // ---------------- reference model ----------------
  function automatic model_t m_reset();
    model_t r;
    r.valid = 1'b0; r.ctrl = '0; r.opcode = '0;
    r.rd1 = '0; r.rd2 = '0; r.imm = '0;
    r.rs = '0; r.rt = '0; r.rd = '0;
    r.bubbles = 0;
    return r;
  endfunction

  // A valid load (MR and EnRW) in EX whose destination the valid ID instruction reads.
  function automatic logic m_load_use(model_t x, stim_t s);
    return x.valid && x.ctrl[3] && x.ctrl[0] && s.in_valid && (x.rd == s.rs || x.rd == s.rt);
  endfunction

  function automatic logic m_hold(model_t x, stim_t s);
    return (s.stall || m_load_use(x, s)) && !s.flush;
  endfunction

  function automatic model_t m_next(model_t x, stim_t s);
    model_t n;
    n = x;
    if (s.flush) begin
      n.valid = 1'b0; n.ctrl = '0;
    end else if (s.stall) begin
      n = x;
    end else if (m_load_use(x, s)) begin
      n.valid = 1'b0; n.ctrl = '0;
      if (n.bubbles < 65535) n.bubbles = n.bubbles + 1;
    end else begin
      n.valid  = s.in_valid;
      n.ctrl   = s.in_valid ? s.ctrl : (s.ctrl & 5'b00010);
      n.opcode = s.opcode;
      n.rd1 = s.rd1; n.rd2 = s.rd2; n.imm = s.imm;
      n.rs = s.rs; n.rt = s.rt; n.rd = s.rd;
    end
    return n;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid"},  valid_out, m.valid);
    check({tag, ".ctrl"},   {MReg_out, MR_out, MW_out, ALU_src_out, EnRW_out}, m.ctrl);
    check({tag, ".opcode"}, opcode_out, m.opcode);
    check({tag, ".data"},   {rd1_out, rd2_out}, {m.rd1, m.rd2});
    check({tag, ".imm"},    sign_ext_out, m.imm);
    check({tag, ".regs"},   {reg_rs_out, reg_rt_out, reg_rd_out}, {m.rs, m.rt, m.rd});
`ifdef IDEX_BUBBLE_CNT_EN
    check({tag, ".bubble_cnt"}, bubble_cnt, m.bubbles);
`endif
  endtask

  // Settle inputs, check id_hold, clock one edge, check registered outputs.
  task automatic step(input string tag);
    #1;
    check({tag, ".id_hold"}, id_hold, m_hold(m, drv));
    @(posedge clk);
    m = m_next(m, drv);
    #1;
    compare_model(tag);
  endtask

  function automatic stim_t mk(logic v, logic [4:0] c, logic [3:0] op, logic [31:0] d,
                               logic [3:0] rs, logic [3:0] rt, logic [3:0] rd,
                               logic st, logic fl);
    stim_t s;
    s.in_valid = v; s.ctrl = c; s.opcode = op;
    s.rd1 = d; s.rd2 = ~d; s.imm = d ^ 32'h0F0F_0000;
    s.rs = rs; s.rt = rt; s.rd = rd;
    s.stall = st; s.flush = fl;
    return s;
  endfunction

  function automatic vec_t mv(stim_t s, logic h, logic v, logic [4:0] c, logic [3:0] op, logic [31:0] d);
    vec_t r;
    r.s = s; r.hold = h; r.valid = v; r.ctrl = c; r.opcode = op; r.rd1 = d;
    return r;
  endfunction

  vec_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Directed sequence: normal flow, load-use bubble, 3-cycle stall, flush over stall+hazard.
    tbl[0] = mv(mk(1, 5'b00001, 4'h3, 32'h0000_00AA, 0, 0, 5, 0, 0), 0, 1, 5'b00001, 4'h3, 32'h0000_00AA);
    tbl[1] = mv(mk(1, 5'b11011, 4'h4, 32'h0000_0011, 0, 0, 5, 0, 0), 0, 1, 5'b11011, 4'h4, 32'h0000_0011);
    tbl[2] = mv(mk(1, 5'b00001, 4'h6, 32'h0000_0022, 5, 3, 7, 0, 0), 1, 0, 5'b00000, 4'h4, 32'h0000_0011);
    tbl[3] = mv(mk(1, 5'b00001, 4'h6, 32'h0000_0022, 5, 3, 7, 0, 0), 0, 1, 5'b00001, 4'h6, 32'h0000_0022);
    tbl[4] = mv(mk(1, 5'b11011, 4'h9, 32'h0000_0033, 0, 0, 8, 1, 0), 1, 1, 5'b00001, 4'h6, 32'h0000_0022);
    tbl[5] = mv(mk(1, 5'b00110, 4'hA, 32'h0000_0044, 1, 2, 3, 1, 0), 1, 1, 5'b00001, 4'h6, 32'h0000_0022);
    tbl[6] = mv(mk(0, 5'b11111, 4'hB, 32'h0000_0055, 4, 5, 6, 1, 0), 1, 1, 5'b00001, 4'h6, 32'h0000_0022);
    tbl[7] = mv(mk(1, 5'b11011, 4'h9, 32'h0000_0033, 0, 0, 8, 0, 0), 0, 1, 5'b11011, 4'h9, 32'h0000_0033);
    tbl[8] = mv(mk(1, 5'b00111, 4'hC, 32'h0000_0066, 8, 1, 2, 1, 1), 0, 0, 5'b00000, 4'h9, 32'h0000_0033);
    tbl[9] = mv(mk(0, 5'b00110, 4'hD, 32'h0000_0077, 8, 1, 2, 0, 0), 0, 0, 5'b00010, 4'hD, 32'h0000_0077);

    // Reset state; ex_stall high to show id_hold stays low under reset.
    drv = mk(0, 5'b00000, 4'h0, 32'h0, 0, 0, 0, 1, 0);
    m = m_reset();
    #12;
    compare_model("reset");
    check("reset.id_hold", id_hold, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drv.stall = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drv = tbl[i].s;
      #1;
      check($sformatf("tbl%0d.hold", i), id_hold, tbl[i].hold);
      step($sformatf("tbl%0d.model", i));
      check($sformatf("tbl%0d.valid", i),  valid_out, tbl[i].valid);
      check($sformatf("tbl%0d.ctrl", i),   {MReg_out, MR_out, MW_out, ALU_src_out, EnRW_out}, tbl[i].ctrl);
      check($sformatf("tbl%0d.opcode", i), opcode_out, tbl[i].opcode);
      check($sformatf("tbl%0d.rd1", i),    rd1_out, tbl[i].rd1);
    end

    // Asynchronous reset between edges while EX holds a valid instruction.
    drv = mk(1, 5'b00001, 4'h3, 32'h0000_00AA, 1, 2, 3, 0, 0);
    step("arst_pre");
    #2;
    rst = 1'b1;
    drv.stall = 1'b1;
    #1;
    m = m_reset();
    check("arst.valid_out", valid_out, 1'b0);
    check("arst.rd1_out", rd1_out, 32'h0);
    check("arst.id_hold", id_hold, 1'b0);
    compare_model("arst");
    @(negedge clk);
    rst = 1'b0;
    drv.stall = 1'b0;
    step("arst_post");
    check("arst_post.valid_out", valid_out, 1'b1);

    // Bubble counting: three load-use bubbles and two flushes from a clean reset.
    rst = 1'b1;
    #1;
    m = m_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drv = mk(1, 5'b11011, 4'h1, 32'h100 + k, 0, 0, 5, 0, 0);
      step($sformatf("bc%0d.load", k));
      drv = mk(1, 5'b00001, 4'h2, 32'h200 + k, 5, 1, 6, 0, 0);
      step($sformatf("bc%0d.bubble", k));
      step($sformatf("bc%0d.use", k));
    end
    drv = mk(1, 5'b11011, 4'h1, 32'h300, 0, 0, 5, 0, 0);
    step("bc.load4");
    drv = mk(1, 5'b00001, 4'h2, 32'h301, 5, 5, 6, 0, 1);
    step("bc.flush1");
    drv = mk(1, 5'b01001, 4'h7, 32'h302, 5, 5, 5, 1, 1);
    step("bc.flush2");
`ifdef IDEX_BUBBLE_CNT_EN
    check("bc.bubble_cnt_eq_3", bubble_cnt, 16'd3);
`endif

    // Randomized traffic against the model; small register range to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      drv.in_valid = ($urandom_range(0, 7) != 0);
      drv.ctrl     = 5'($urandom);
      drv.opcode   = 4'($urandom);
      drv.rd1      = $urandom;
      drv.rd2      = $urandom;
      drv.imm      = $urandom;
      drv.rs       = 4'($urandom_range(0, 3));
      drv.rt       = 4'($urandom_range(0, 3));
      drv.rd       = 4'($urandom_range(0, 3));
      drv.stall    = ($urandom_range(0, 5) == 0);
      drv.flush    = ($urandom_range(0, 9) == 0);
      step($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idex_stage_reg.md
IDEX_STAGE_REG -- requirements
Module: idex_stage_reg

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, width of operand/immediate fields; REG_AW, default 4, register-address width; OP_W, default 4, opcode width.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  ID stage holds a real instruction.
- MReg, MR, MW, ALU_src, EnRW  in  1 each  decoded control bits.
- opcode  in  OP_W.
- rd1_in, rd2_in, sign_ext_in  in  DATA_W each.
- reg_rs_in, reg_rt_in, reg_rd_in  in  REG_AW each.
- ex_stall  in  1  downstream stall; hold stage.
- flush  in  1  squash stage contents (branch/exception).
- valid_out  out  1  EX stage holds a real instruction.
- MReg_out, MR_out, MW_out, ALU_src_out, EnRW_out  out  1 each.
- opcode_out  out  OP_W.
- rd1_out, rd2_out, sign_ext_out  out  DATA_W each.
- reg_rs_out, reg_rt_out, reg_rd_out  out  REG_AW each.
- id_hold  out  1  combinational; IF/ID must not advance this cycle.
- bubble_cnt  out  16  inserted-bubble count (only with IDEX_BUBBLE_CNT_EN).

Function
REQ-003 SHALL register all inputs with 1-cycle latency when no stall, flush or hazard is active; valid_out <= in_valid.
REQ-004 SHALL detect load-use combinationally: load_use = valid_out & MR_out & EnRW_out & in_valid & (reg_rd_out == reg_rs_in | reg_rd_out == reg_rt_in).
REQ-005 SHALL apply per-edge priority: rst > flush > ex_stall > load_use > normal load.
REQ-006 On flush: valid_out <= 0; MReg/MR/MW/EnRW/ALU_src outputs <= 0; data, opcode and register fields hold their previous values.
REQ-007 On ex_stall (no flush): every output register holds its value, including valid_out.
REQ-008 On load_use (no flush, no ex_stall): insert bubble -- valid_out <= 0, control outputs <= 0, data fields hold.
REQ-009 id_hold SHALL be (ex_stall | load_use) & ~flush.
REQ-010 Bubble output (valid_out = 0) SHALL always carry MR_out = MW_out = EnRW_out = MReg_out = 0, so no memory or register-file side effect escapes.
REQ-011 Load_use SHALL never assert when valid_out = 0; a single bubble resolves a one-deep load-use stall (next cycle MR_out = 0).
REQ-012 Simultaneous flush and load_use: flush wins; id_hold = 0.

Reset
REQ-013 On rst = 1, immediately and irrespective of clk: valid_out, all control outputs, opcode_out, all data and register fields, and bubble_cnt <= 0.
REQ-014 Deassertion of rst SHALL take effect at the next rising clk edge; id_hold SHALL be 0 while rst = 1.

Configuration
REQ-015 Macro IDEX_BUBBLE_CNT_EN defined: bubble_cnt increments by 1 on each edge where a load_use bubble is inserted (REQ-008), saturating at 16'hFFFF; flush and ex_stall cycles do not count.
REQ-016 Macro undefined: bubble_cnt port absent and no counter logic instantiated; all other behaviour identical.

Structure
REQ-017 Parameter defaults (DATA_W, REG_AW, OP_W) and a packed control-bundle typedef (MReg, MR, MW, ALU_src, EnRW) SHALL live in the shared pipeline package, reused by the EX/MEM and MEM/WB stage registers.
REQ-018 The load-use comparator SHALL be a separate sub-module, idex_hazard_detect (inputs: EX valid/MR/EnRW/rd, ID valid/rs/rt; output load_use).

Verification
REQ-019 Directed scenarios the bench SHALL cover:
- Normal flow: in_valid = 1, opcode = 4'h3, rd1_in = 32'h0000_00AA -> next edge valid_out = 1, opcode_out = 4'h3, rd1_out = 32'h0000_00AA.
- Load-use: EX holds MR = 1, EnRW = 1, rd = 4'd5; ID presents rs = 4'd5 -> id_hold = 1 same cycle; next edge valid_out = 0, MR_out = 0; following edge ID instruction loads, id_hold = 0.
- ex_stall held 3 cycles with changing inputs -> all outputs unchanged for 3 edges; id_hold = 1.
- flush asserted together with ex_stall and a load-use match -> next edge valid_out = 0, MW_out = 0, EnRW_out = 0; id_hold = 0.
- Async reset mid-stream: rst pulsed between clock edges with valid_out = 1 -> valid_out = 0 and rd1_out = 0 before the next edge.
- With IDEX_BUBBLE_CNT_EN: 3 load-use bubbles plus 2 flushes -> bubble_cnt = 3.
